// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - bit-strobe input and frame result bundle for serial_frame_rx
//
// Purpose: groups the serial input strobe/data and the parallel frame results
//          of serial_frame_rx into one port.
// Signals:
//   enable      bit strobe shared with the upstream shifter
//   serial_in   serial bit stream (upstream shiftout)
//   data_out    last payload that passed parity
//   data_valid  one-cycle pulse, data_out updated
//   parity_err  one-cycle pulse, frame dropped on parity
//   frame_count good frames, modulo 2^CNT_WIDTH
//   busy        receiver is inside a frame (DATA or PARITY)
// Modports:
//   master  bit source / result consumer
//   slave   the receiver itself
interface serial_frame_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  enable;
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic [CNT_WIDTH-1:0]  frame_count;
    logic                  busy;

    modport master (
        output enable,
        output serial_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_count,
        input  busy
    );

    modport slave (
        input  enable,
        input  serial_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_count,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - sync-word framed serial receiver with even parity check
//
// Purpose: hunts an MSB-first serial stream for SYNC_PATTERN, captures one
//          DATA_WIDTH-bit payload plus one even-parity bit, and presents good
//          payloads as a parallel word with a one-cycle valid pulse.
// Ports:
//   clock  rising-edge clock
//   sclr   synchronous active-high clear, overrides everything
//   rx     serial_frame_rx_if.slave: enable, serial_in in;
//          data_out, data_valid, parity_err, frame_count, busy out
module serial_frame_rx #(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = DATA_WIDTH'(8'hA5),
    parameter int                    CNT_WIDTH    = 8
) (
    input  logic              clock,
    input  logic              sclr,
    serial_frame_rx_if.slave  rx
);
    // Wide enough to hold the value DATA_WIDTH itself (saturated fill level).
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                r_state,       w_state_nxt;
    logic [DATA_WIDTH-1:0] r_window,      w_window_nxt;
    logic [CW-1:0]         r_fill,        w_fill_nxt;
    logic [CW-1:0]         r_bitcnt,      w_bitcnt_nxt;
    logic [DATA_WIDTH-1:0] r_shreg,       w_shreg_nxt;
    logic [DATA_WIDTH-1:0] r_data_out,    w_data_out_nxt;
    logic                  r_data_valid,  w_data_valid_nxt;
    logic                  r_parity_err,  w_parity_err_nxt;
    logic [CNT_WIDTH-1:0]  r_frame_count, w_frame_count_nxt;

    logic [DATA_WIDTH-1:0] w_window_shift;
    logic [DATA_WIDTH-1:0] w_shreg_shift;
    logic                  w_window_full;
    logic                  w_sync_hit;
    logic                  w_parity_ok;

    assign w_window_shift = {r_window[DATA_WIDTH-2:0], rx.serial_in};
    assign w_shreg_shift  = {r_shreg[DATA_WIDTH-2:0], rx.serial_in};

    // The match looks at the window after this bit shifts in, so the window is
    // complete once fill+1 reaches DATA_WIDTH. Gating on fill keeps the zero
    // reset value of the window from matching an all-zero sync word early.
    assign w_window_full = (r_fill >= CW'(DATA_WIDTH - 1));
    assign w_sync_hit    = w_window_full && (w_window_shift == SYNC_PATTERN);

    // Even parity over payload plus parity bit.
    assign w_parity_ok   = ~((^r_shreg) ^ rx.serial_in);

    always_ff @(posedge clock) begin
        if (sclr) begin
            r_state       <= HUNT;
            r_window      <= '0;
            r_fill        <= '0;
            r_bitcnt      <= '0;
            r_shreg       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_window      <= w_window_nxt;
            r_fill        <= w_fill_nxt;
            r_bitcnt      <= w_bitcnt_nxt;
            r_shreg       <= w_shreg_nxt;
            r_data_out    <= w_data_out_nxt;
            r_data_valid  <= w_data_valid_nxt;
            r_parity_err  <= w_parity_err_nxt;
            r_frame_count <= w_frame_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_window_nxt      = r_window;
        w_fill_nxt        = r_fill;
        w_bitcnt_nxt      = r_bitcnt;
        w_shreg_nxt       = r_shreg;
        w_data_out_nxt    = r_data_out;
        w_frame_count_nxt = r_frame_count;
        // Pulses drop after one cycle regardless of the strobe.
        w_data_valid_nxt  = 1'b0;
        w_parity_err_nxt  = 1'b0;

        if (rx.enable) begin
            case (r_state)
                HUNT: begin
                    w_window_nxt = w_window_shift;
                    if (r_fill != CW'(DATA_WIDTH)) begin
                        w_fill_nxt = r_fill + CW'(1);
                    end
                    if (w_sync_hit) begin
                        w_state_nxt  = DATA;
                        w_bitcnt_nxt = '0;
                        w_shreg_nxt  = '0;
                    end
                end

                // Payload bits are never checked against the sync word here.
                DATA: begin
                    w_shreg_nxt  = w_shreg_shift;
                    w_bitcnt_nxt = r_bitcnt + CW'(1);
                    if (r_bitcnt == CW'(DATA_WIDTH - 1)) begin
                        w_state_nxt = PARITY;
                    end
                end

                PARITY: begin
                    if (w_parity_ok) begin
                        w_data_out_nxt    = r_shreg;
                        w_data_valid_nxt  = 1'b1;
                        w_frame_count_nxt = r_frame_count + CNT_WIDTH'(1);
                    end else begin
                        w_parity_err_nxt  = 1'b1;
                    end
                    // Next frame must bring a complete sync word of its own.
                    w_state_nxt  = HUNT;
                    w_window_nxt = '0;
                    w_fill_nxt   = '0;
                    w_bitcnt_nxt = '0;
                end

                default: begin
                    w_state_nxt  = HUNT;
                    w_window_nxt = '0;
                    w_fill_nxt   = '0;
                    w_bitcnt_nxt = '0;
                end
            endcase
        end
    end

    assign rx.data_out    = r_data_out;
    assign rx.data_valid  = r_data_valid;
    assign rx.parity_err  = r_parity_err;
    assign rx.frame_count = r_frame_count;
    assign rx.busy        = (r_state != HUNT);

endmodule
